// File: rtl/cu_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, FSM states, decode helpers.
package cu_pkg;

    localparam int unsigned OPC_W = 4;

    localparam logic [OPC_W-1:0] OP_LD  = 4'h0;
    localparam logic [OPC_W-1:0] OP_ST  = 4'h1;
    localparam logic [OPC_W-1:0] OP_MI  = 4'h2;
    localparam logic [OPC_W-1:0] OP_MR  = 4'h3;
    localparam logic [OPC_W-1:0] OP_SUM = 4'h4;
    localparam logic [OPC_W-1:0] OP_SB  = 4'h5;
    localparam logic [OPC_W-1:0] OP_ANR = 4'h6;
    localparam logic [OPC_W-1:0] OP_CM  = 4'h7;
    localparam logic [OPC_W-1:0] OP_ORR = 4'h8;
    localparam logic [OPC_W-1:0] OP_ORI = 4'h9;
    localparam logic [OPC_W-1:0] OP_XRR = 4'hA;
    localparam logic [OPC_W-1:0] OP_XRI = 4'hB;
    localparam logic [OPC_W-1:0] OP_SMI = 4'hC;
    localparam logic [OPC_W-1:0] OP_SBI = 4'hD;
    localparam logic [OPC_W-1:0] OP_ANI = 4'hE;
    localparam logic [OPC_W-1:0] OP_CMI = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    // ALU forms whose operand B comes from the instruction's low field
    function automatic logic is_imm_op(input logic [OPC_W-1:0] op);
        logic r;
        case (op)
            OP_MI, OP_SMI, OP_SBI, OP_CMI, OP_ANI, OP_ORI, OP_XRI: r = 1'b1;
            default:                                              r = 1'b0;
        endcase
        return r;
    endfunction

    // Loads and stores go through the MEM state instead of EXEC
    function automatic logic is_mem_op(input logic [OPC_W-1:0] op);
        return (op == OP_LD) || (op == OP_ST);
    endfunction

endpackage

// File: rtl/cu_imm_ext.sv
// Combinational sign extender from an IN_W-bit field to DATA_W bits.
module cu_imm_ext #(
    parameter int unsigned IN_W   = 2,
    parameter int unsigned DATA_W = 8
) (
    input  logic [IN_W-1:0]   in_i,
    output logic [DATA_W-1:0] out_o
);

    // Sized cast of a signed operand replicates the sign bit
    assign out_o = DATA_W'($signed(in_i));

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit: accepts an instruction over valid/ready, then sequences
// FETCH/DECODE/EXEC/MEM/WB while driving registered control and immediate outputs.
// Optional feature macro CU_PERF_EN adds retired/stall performance counters.
module multicycle_control_unit
    import cu_pkg::*;
#(
    parameter  int unsigned REG_AW = 2,
    parameter  int unsigned DATA_W = 8,
    localparam int unsigned INST_W = OPC_W + 2 * REG_AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [INST_W-1:0] inst,
    input  logic              inst_valid,
    output logic              inst_ready,
    input  logic              mem_ack,
    output logic [OPC_W-1:0]  opcode,
    output logic [REG_AW-1:0] rd,
    output logic [REG_AW-1:0] rs,
    output logic [DATA_W-1:0] immediate_value,
    output logic              imm,
    output logic              alu_src,
    output logic              mem_read,
    output logic              mem_write,
    output logic              reg_write,
    output logic              busy
`ifdef CU_PERF_EN
    ,
    output logic [31:0]       retired_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    state_e              state_q, state_d;
    logic [INST_W-1:0]   ir_q, ir_d;
    logic [OPC_W-1:0]    opcode_q, opcode_d;
    logic [REG_AW-1:0]   rd_q, rd_d;
    logic [REG_AW-1:0]   rs_q, rs_d;
    logic [DATA_W-1:0]   immv_q, immv_d;
    logic                imm_q, imm_d;
    logic                alu_src_q, alu_src_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic                reg_write_q, reg_write_d;
    logic                inst_ready_q, inst_ready_d;
    logic                busy_q, busy_d;

    logic [OPC_W-1:0]    ir_op;
    logic [REG_AW-1:0]   ir_hi;
    logic [REG_AW-1:0]   ir_lo;
    logic [DATA_W-1:0]   imm_mem;
    logic [DATA_W-1:0]   imm_alu;

    assign ir_op = ir_q[INST_W-1 -: OPC_W];
    assign ir_hi = ir_q[2*REG_AW-1 -: REG_AW];
    assign ir_lo = ir_q[REG_AW-1:0];

    // Memory address immediate: whole operand field
    cu_imm_ext #(
        .IN_W   (2 * REG_AW),
        .DATA_W (DATA_W)
    ) u_ext_mem (
        .in_i  (ir_q[2*REG_AW-1:0]),
        .out_o (imm_mem)
    );

    // ALU immediate: low register-sized field
    cu_imm_ext #(
        .IN_W   (REG_AW),
        .DATA_W (DATA_W)
    ) u_ext_alu (
        .in_i  (ir_lo),
        .out_o (imm_alu)
    );

    // Next state, decode capture and strobes; strobes follow the state being entered
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        opcode_d  = opcode_q;
        rd_d      = rd_q;
        rs_d      = rs_q;
        immv_d    = immv_q;
        imm_d     = imm_q;
        alu_src_d = alu_src_q;

        case (state_q)
            S_FETCH: begin
                if (inst_valid) begin
                    ir_d    = inst;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                opcode_d = ir_op;
                if (is_mem_op(ir_op)) begin
                    rd_d      = '0;
                    rs_d      = '0;
                    imm_d     = 1'b1;
                    alu_src_d = 1'b1;
                    immv_d    = imm_mem;
                    state_d   = S_MEM;
                end else if (is_imm_op(ir_op)) begin
                    rd_d      = ir_hi;
                    rs_d      = '0;
                    imm_d     = 1'b1;
                    alu_src_d = 1'b1;
                    immv_d    = imm_alu;
                    state_d   = S_EXEC;
                end else begin
                    rd_d      = ir_hi;
                    rs_d      = ir_lo;
                    imm_d     = 1'b0;
                    alu_src_d = 1'b0;
                    immv_d    = '0;
                    state_d   = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_WB;
            end
            S_MEM: begin
                if (mem_ack) begin
                    state_d = (opcode_q == OP_LD) ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        inst_ready_d = (state_d == S_FETCH);
        busy_d       = (state_d != S_FETCH);
        reg_write_d  = (state_d == S_WB);
        mem_read_d   = (state_d == S_MEM) && (opcode_d == OP_LD);
        mem_write_d  = (state_d == S_MEM) && (opcode_d == OP_ST);
    end

    // State, instruction register and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_FETCH;
            ir_q         <= '0;
            opcode_q     <= '0;
            rd_q         <= '0;
            rs_q         <= '0;
            immv_q       <= '0;
            imm_q        <= 1'b0;
            alu_src_q    <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            reg_write_q  <= 1'b0;
            inst_ready_q <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ir_q         <= ir_d;
            opcode_q     <= opcode_d;
            rd_q         <= rd_d;
            rs_q         <= rs_d;
            immv_q       <= immv_d;
            imm_q        <= imm_d;
            alu_src_q    <= alu_src_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            reg_write_q  <= reg_write_d;
            inst_ready_q <= inst_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign inst_ready      = inst_ready_q;
    assign opcode          = opcode_q;
    assign rd              = rd_q;
    assign rs              = rs_q;
    assign immediate_value = immv_q;
    assign imm             = imm_q;
    assign alu_src         = alu_src_q;
    assign mem_read        = mem_read_q;
    assign mem_write       = mem_write_q;
    assign reg_write       = reg_write_q;
    assign busy            = busy_q;

`ifdef CU_PERF_EN
    logic [31:0] retired_q, retired_d;
    logic [31:0] stall_q, stall_d;

    // Retire on leaving WB or on a store completing; stall on each un-acked MEM cycle
    always_comb begin
        retired_d = retired_q;
        stall_d   = stall_q;
        if ((state_q == S_WB) ||
            ((state_q == S_MEM) && mem_ack && (opcode_q == OP_ST))) begin
            retired_d = retired_q + 32'd1;
        end
        if ((state_q == S_MEM) && !mem_ack) begin
            stall_d = stall_q + 32'd1;
        end
    end

    // Counter registers, wrapping naturally at 2^32
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            retired_q <= retired_d;
            stall_q   <= stall_d;
        end
    end

    assign retired_cnt = retired_q;
    assign stall_cnt   = stall_q;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit with a decode scoreboard.
// Exercises both the default build and CU_PERF_EN when that macro is defined.
module tb_multicycle_control_unit;

    logic        clk = 1'b0;
    logic        reset;

    // 8-bit instruction instance (REG_AW=2, DATA_W=8)
    logic [7:0]  inst;
    logic        inst_valid, mem_ack;
    logic        inst_ready, imm, alu_src, mem_read, mem_write, reg_write, busy;
    logic [3:0]  opcode;
    logic [1:0]  rd, rs;
    logic [7:0]  immediate_value;

    // 10-bit instruction instance (REG_AW=3, DATA_W=16)
    logic [9:0]  inst2;
    logic        inst_valid2, mem_ack2;
    logic        inst_ready2, imm2, alu_src2, mem_read2, mem_write2, reg_write2, busy2;
    logic [3:0]  opcode2;
    logic [2:0]  rd2, rs2;
    logic [15:0] immediate_value2;

`ifdef CU_PERF_EN
    logic [31:0] retired_cnt, stall_cnt, retired_cnt2, stall_cnt2;
    int          exp_retired, exp_stall;
`endif

    int n_chk = 0;
    int n_err = 0;

    typedef struct packed {
        logic [3:0] op;
        logic [1:0] rd;
        logic [1:0] rs;
        logic       imm;
        logic       alu;
        logic [7:0] immv;
        logic       ld;
        logic       st;
    } exp_t;

    exp_t sb_q[$];

    typedef struct packed {
        logic [7:0] ins;
        logic [3:0] w;
        logic       ack_noise;
        logic       valid_noise;
    } step_t;

    always #5 clk = ~clk;

    multicycle_control_unit #(.REG_AW(2), .DATA_W(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .inst            (inst),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .mem_ack         (mem_ack),
        .opcode          (opcode),
        .rd              (rd),
        .rs              (rs),
        .immediate_value (immediate_value),
        .imm             (imm),
        .alu_src         (alu_src),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .reg_write       (reg_write),
        .busy            (busy)
`ifdef CU_PERF_EN
        ,
        .retired_cnt     (retired_cnt),
        .stall_cnt       (stall_cnt)
`endif
    );

    multicycle_control_unit #(.REG_AW(3), .DATA_W(16)) dut2 (
        .clk             (clk),
        .reset           (reset),
        .inst            (inst2),
        .inst_valid      (inst_valid2),
        .inst_ready      (inst_ready2),
        .mem_ack         (mem_ack2),
        .opcode          (opcode2),
        .rd              (rd2),
        .rs              (rs2),
        .immediate_value (immediate_value2),
        .imm             (imm2),
        .alu_src         (alu_src2),
        .mem_read        (mem_read2),
        .mem_write       (mem_write2),
        .reg_write       (reg_write2),
        .busy            (busy2)
`ifdef CU_PERF_EN
        ,
        .retired_cnt     (retired_cnt2),
        .stall_cnt       (stall_cnt2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Reference decode of an 8-bit instruction
    function automatic exp_t model(input logic [7:0] ins);
        exp_t e;
        e.op = ins[7:4];
        e.ld = (ins[7:4] == 4'h0);
        e.st = (ins[7:4] == 4'h1);
        case (ins[7:4])
            4'h0, 4'h1: begin
                e.rd = 2'd0; e.rs = 2'd0; e.imm = 1'b1; e.alu = 1'b1;
                e.immv = {{4{ins[3]}}, ins[3:0]};
            end
            4'h2, 4'h9, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF: begin
                e.rd = ins[3:2]; e.rs = 2'd0; e.imm = 1'b1; e.alu = 1'b1;
                e.immv = {{6{ins[1]}}, ins[1:0]};
            end
            default: begin
                e.rd = ins[3:2]; e.rs = ins[1:0]; e.imm = 1'b0; e.alu = 1'b0;
                e.immv = 8'h00;
            end
        endcase
        return e;
    endfunction

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_inst_ready"}, inst_ready, 1);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_opcode"}, opcode, 0);
        chk({pfx, "_rd"}, rd, 0);
        chk({pfx, "_rs"}, rs, 0);
        chk({pfx, "_immv"}, immediate_value, 0);
        chk({pfx, "_imm"}, imm, 0);
        chk({pfx, "_alu_src"}, alu_src, 0);
        chk({pfx, "_mem_read"}, mem_read, 0);
        chk({pfx, "_mem_write"}, mem_write, 0);
        chk({pfx, "_reg_write"}, reg_write, 0);
    endtask

    // Issue one instruction at a negedge in FETCH and follow it back to FETCH.
    // w = un-acked MEM cycles before the ack; noise flags toggle ignored inputs.
    task automatic issue(input step_t s);
        exp_t e, got;
        int   rw_cnt, rw_cyc, mem_cnt, rdy_cyc, exp_rw, exp_rdy, exp_mem;
        bit   popped;
        chk("ready_before_issue", inst_ready, 1);
        e = model(s.ins);
        sb_q.push_back(e);
        inst       = s.ins;
        inst_valid = 1'b1;
        rw_cnt = 0; rw_cyc = -1; mem_cnt = 0; rdy_cyc = -1; popped = 1'b0;
        for (int k = 1; k <= 40 && rdy_cyc < 0; k++) begin
            @(negedge clk);
            if (k == 1) chk("busy_in_decode", busy, 1);
            if (s.valid_noise && !inst_ready) begin
                inst       = 8'hE7;
                inst_valid = 1'b1;
            end else begin
                inst_valid = 1'b0;
            end
            if (reg_write) begin
                rw_cnt++;
                rw_cyc = k;
            end
            if (mem_read || mem_write) begin
                mem_cnt++;
                mem_ack = (mem_cnt > int'(s.w));
            end else begin
                mem_ack = s.ack_noise;
            end
            if (!popped && (reg_write || mem_read || mem_write)) begin
                popped = 1'b1;
                got = sb_q.pop_front();
                chk("opcode", opcode, got.op);
                chk("rd", rd, got.rd);
                chk("rs", rs, got.rs);
                chk("imm", imm, got.imm);
                chk("alu_src", alu_src, got.alu);
                chk("immediate_value", immediate_value, got.immv);
                chk("mem_read_kind", mem_read, got.ld);
                chk("mem_write_kind", mem_write, got.st);
            end
            if (inst_ready) rdy_cyc = k;
        end
        mem_ack    = 1'b0;
        inst_valid = 1'b0;
        if (e.st)      begin exp_rw = -1;        exp_rdy = 3 + int'(s.w); exp_mem = int'(s.w) + 1; end
        else if (e.ld) begin exp_rw = 3 + int'(s.w); exp_rdy = 4 + int'(s.w); exp_mem = int'(s.w) + 1; end
        else           begin exp_rw = 3;         exp_rdy = 4;         exp_mem = 0;         end
        chk("output_seen", 32'(popped), 1);
        chk("reg_write_count", rw_cnt, e.st ? 0 : 1);
        chk("reg_write_cycle", rw_cyc, exp_rw);
        chk("mem_req_cycles", mem_cnt, exp_mem);
        chk("ready_return_cycle", rdy_cyc, exp_rdy);
        chk("busy_back_in_fetch", busy, 0);
        chk("opcode_stable", opcode, e.op);
        chk("immv_stable", immediate_value, e.immv);
`ifdef CU_PERF_EN
        exp_retired++;
        if (e.ld || e.st) exp_stall += int'(s.w);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        step_t steps[10];
        int    rdy2, rw2;

        steps[0] = '{ins: 8'h46, w: 4'd0, ack_noise: 1'b1, valid_noise: 1'b0}; // SUM r1,r2
        steps[1] = '{ins: 8'h2B, w: 4'd0, ack_noise: 1'b0, valid_noise: 1'b1}; // MI r2,#-1
        steps[2] = '{ins: 8'h0A, w: 4'd3, ack_noise: 1'b1, valid_noise: 1'b0}; // LD #-6
        steps[3] = '{ins: 8'h15, w: 4'd0, ack_noise: 1'b0, valid_noise: 1'b0}; // ST #5
        steps[4] = '{ins: 8'hFD, w: 4'd0, ack_noise: 1'b0, valid_noise: 1'b0}; // CMI r3,#1
        steps[5] = '{ins: 8'hE6, w: 4'd0, ack_noise: 1'b0, valid_noise: 1'b0}; // ANI r1,#-2
        steps[6] = '{ins: 8'hA7, w: 4'd0, ack_noise: 1'b0, valid_noise: 1'b1}; // XRR r1,r3
        steps[7] = '{ins: 8'h18, w: 4'd2, ack_noise: 1'b1, valid_noise: 1'b0}; // ST #-8
        steps[8] = '{ins: 8'h34, w: 4'd0, ack_noise: 1'b0, valid_noise: 1'b0}; // MR r1,r0
        steps[9] = '{ins: 8'h07, w: 4'd1, ack_noise: 1'b0, valid_noise: 1'b0}; // LD #7

        inst = '0; inst_valid = 1'b0; mem_ack = 1'b0;
        inst2 = '0; inst_valid2 = 1'b0; mem_ack2 = 1'b0;
`ifdef CU_PERF_EN
        exp_retired = 0;
        exp_stall   = 0;
`endif
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("por");
        reset = 1'b1;
        @(negedge clk);

        // Abort an LD mid-MEM with an asynchronous reset
        inst = 8'h0A; inst_valid = 1'b1;
        @(negedge clk);
        inst_valid = 1'b0;
        @(negedge clk);
        chk("abort_mem_read_before", mem_read, 1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 chk_reset_outputs("async");
        @(negedge clk);
        mem_ack = 1'b1;
        reset   = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("abort_no_reg_write", reg_write, 0);
            chk("abort_no_mem_read", mem_read, 0);
            chk("abort_ready", inst_ready, 1);
        end
        mem_ack = 1'b0;

        foreach (steps[i]) issue(steps[i]);
        chk("scoreboard_empty", sb_q.size(), 0);

`ifdef CU_PERF_EN
        chk("retired_cnt", retired_cnt, exp_retired);
        chk("stall_cnt", stall_cnt, exp_stall);
`endif

        // Wide instance: MI r3,#3 encoded as 0010_011_011
        inst2 = 10'h09B; inst_valid2 = 1'b1;
        rdy2 = -1; rw2 = 0;
        for (int k = 1; k <= 20 && rdy2 < 0; k++) begin
            @(negedge clk);
            inst_valid2 = 1'b0;
            if (reg_write2) rw2++;
            if (inst_ready2) rdy2 = k;
        end
        chk("w_opcode", opcode2, 4'h2);
        chk("w_rd", rd2, 3);
        chk("w_rs", rs2, 0);
        chk("w_imm", imm2, 1);
        chk("w_alu_src", alu_src2, 1);
        chk("w_immediate_value", immediate_value2, 16'h0003);
        chk("w_reg_write_count", rw2, 1);
        chk("w_ready_cycle", rdy2, 4);
        chk("w_no_mem", 32'({mem_read2, mem_write2}), 0);
`ifdef CU_PERF_EN
        chk("w_retired_cnt", retired_cnt2, 1);
        chk("w_stall_cnt", stall_cnt2, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
